spi_slave: RTL and testbench

SPI responder for the FPGA-side SPI link. It pairs with the on-chip SPI master, using mode 3:
- SCK idles high; data changes on the falling edge and is sampled on the rising edge.
- SS is active-low; MSB first.
- It receives an RX_DATA_LEN-bit command word on MOSI and returns a TX_DATA_LEN-bit response on MISO in the same frame.
All pin inputs are oversampled in the clk domain. No logic is clocked by SCK.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_slave_if.sv | 32 +++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_slave.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: FSM state encoding, link mode
// constants and default frame lengths.
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE         = 2'd0;
  localparam state_t ST_SHIFT        = 2'd1;
  localparam state_t ST_DONE         = 2'd2;
  localparam state_t ST_WAIT_SS_HIGH = 2'd3;

  localparam int SPI_MODE  = 3;
  localparam int MSB_FIRST = 1;

  localparam int DEF_RX_DATA_LEN = 12;
  localparam int DEF_TX_DATA_LEN = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_if.sv
// Bundles the SPI pins and the local command/response handshake of the
// SPI responder. The slave modport is the responder's view.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int RX_DATA_LEN = DEF_RX_DATA_LEN,
  parameter int TX_DATA_LEN = DEF_TX_DATA_LEN
);

  logic                   sck;
  logic                   ss;
  logic                   mosi;
  logic                   miso;
  logic                   miso_oe;
  logic [TX_DATA_LEN-1:0] tx_data;
  logic                   tx_load;
  logic [RX_DATA_LEN-1:0] rx_data;
  logic                   rx_valid;
  logic                   busy;
  logic                   err;

  modport slave (
    input  sck, ss, mosi, tx_data, tx_load,
    output miso, miso_oe, rx_data, rx_valid, busy, err
  );

  modport master (
    output sck, ss, mosi, tx_data, tx_load,
    input  miso, miso_oe, rx_data, rx_valid, busy, err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin plus a one-cycle delayed copy of
// the synchronized level, giving single-cycle rise/fall strobes.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES  = DEF_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              dly_r;

  // Shift the pin through the synchronizer chain and keep a delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= {STAGES{RST_VAL}};
      dly_r   <= RST_VAL;
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
      dly_r <= chain_r[STAGES-1];
    end
  end

  assign level = chain_r[STAGES-1];
  assign rise  = chain_r[STAGES-1] & ~dly_r;
  assign fall  = ~chain_r[STAGES-1] & dly_r;

endmodule

// File: rtl/spi_slave.sv
// Mode-3 SPI responder, fully oversampled in the clk domain. Receives an
// RX_DATA_LEN-bit command on mosi and returns a TX_DATA_LEN-bit response on
// miso in the same frame.
module spi_slave
  import spi_pkg::*;
#(
  parameter int RX_DATA_LEN = DEF_RX_DATA_LEN,
  parameter int TX_DATA_LEN = DEF_TX_DATA_LEN,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic      clk,
  input logic      rst,
  spi_slave_if.slave bus
);

  localparam int             CW      = $clog2(RX_DATA_LEN + 1);
  localparam logic [CW-1:0]  RX_LIM  = CW'(RX_DATA_LEN);
  localparam logic [CW-1:0]  RX_LAST = CW'(RX_DATA_LEN - 1);
  localparam logic [CW-1:0]  TX_LIM  = CW'(TX_DATA_LEN);

  logic sck_level_unused_s;
  logic sck_rise_s;
  logic sck_fall_s;
  logic ss_level_s;
  logic ss_rise_s;
  logic ss_fall_s;
  logic mosi_s;
  logic mosi_rise_unused_s;
  logic mosi_fall_unused_s;

  state_t                 state_r;
  logic [TX_DATA_LEN-1:0] hold_r;
  logic [TX_DATA_LEN-1:0] tx_shift_r;
  logic [RX_DATA_LEN-1:0] rx_shift_r;
  logic [CW-1:0]          tx_cnt_r;
  logic [CW-1:0]          rx_cnt_r;
  logic                   miso_r;
  logic                   miso_oe_r;
  logic [RX_DATA_LEN-1:0] rx_data_r;
  logic                   rx_valid_r;
  logic                   busy_r;
  logic                   err_r;

  // sck idles high, so its chain resets high to avoid a false fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sck_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.sck),
    .level (sck_level_unused_s),
    .rise  (sck_rise_s),
    .fall  (sck_fall_s)
  );

  // ss resets low so the FSM only leaves WAIT_SS_HIGH once ss is seen high.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.ss),
    .level (ss_level_s),
    .rise  (ss_rise_s),
    .fall  (ss_fall_s)
  );

  // mosi uses the same chain depth so it stays aligned with the sck edges.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused_s),
    .fall  (mosi_fall_unused_s)
  );

  // Response holding register; survives frames so the reply repeats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
    end else if (bus.tx_load) begin
      hold_r <= bus.tx_data;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Frame FSM with its shift registers, saturating counters and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_WAIT_SS_HIGH;
      tx_shift_r <= '0;
      rx_shift_r <= '0;
      tx_cnt_r   <= '0;
      rx_cnt_r   <= '0;
      miso_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      err_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ss_fall_s) begin
            tx_shift_r <= hold_r;
            rx_shift_r <= '0;
            tx_cnt_r   <= '0;
            rx_cnt_r   <= '0;
            busy_r     <= 1'b1;
            miso_oe_r  <= 1'b1;
            miso_r     <= 1'b0;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sck_rise_s && (rx_cnt_r == RX_LAST)) begin
            // Completion beats a coincident ss rise.
            rx_shift_r <= {rx_shift_r[RX_DATA_LEN-2:0], mosi_s};
            rx_data_r  <= {rx_shift_r[RX_DATA_LEN-2:0], mosi_s};
            rx_cnt_r   <= RX_LIM;
            rx_valid_r <= 1'b1;
            if (ss_rise_s) begin
              busy_r    <= 1'b0;
              miso_oe_r <= 1'b0;
              miso_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              state_r   <= ST_DONE;
            end
          end else if (ss_rise_s) begin
            // Aborted frame: any coincident sck edge is discarded.
            err_r     <= 1'b1;
            busy_r    <= 1'b0;
            miso_oe_r <= 1'b0;
            miso_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (sck_rise_s) begin
            rx_shift_r <= {rx_shift_r[RX_DATA_LEN-2:0], mosi_s};
            if (rx_cnt_r != RX_LIM) begin
              rx_cnt_r <= rx_cnt_r + 1'b1;
            end
          end else if (sck_fall_s) begin
            if (tx_cnt_r == TX_LIM) begin
              miso_r <= 1'b0;
            end else begin
              miso_r     <= tx_shift_r[TX_DATA_LEN-1];
              tx_shift_r <= tx_shift_r << 1;
              tx_cnt_r   <= tx_cnt_r + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ss_rise_s) begin
            busy_r    <= 1'b0;
            miso_oe_r <= 1'b0;
            miso_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        ST_WAIT_SS_HIGH: begin
          busy_r    <= 1'b0;
          miso_oe_r <= 1'b0;
          miso_r    <= 1'b0;
          if (ss_level_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r    <= 1'b0;
          miso_oe_r <= 1'b0;
          miso_r    <= 1'b0;
          state_r   <= ST_WAIT_SS_HIGH;
        end
      endcase
    end
  end

  assign bus.miso     = miso_r;
  assign bus.miso_oe  = miso_oe_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.busy     = busy_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-3 master drives frames, a frame-level
// model predicts rx words and the miso response, and a per-cycle monitor
// checks the outputs against that model.
module tb_spi_slave;

  localparam int HALF = 5;

  logic clk;
  logic rst;

  spi_slave_if #(.RX_DATA_LEN(12), .TX_DATA_LEN(8)) bus ();

  spi_slave #(.RX_DATA_LEN(12), .TX_DATA_LEN(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total;
  int bad;
  int valid_cnt;
  int err_cnt;
  logic [11:0] exp_q[$];
  logic [11:0] model_rx;
  logic [7:0]  exp_hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor against the frame-level model.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("rx_valid_unexpected", 32'd1, 32'd0);
        end else begin
          model_rx = exp_q.pop_front();
          check("rx_data_word", {20'd0, bus.rx_data}, {20'd0, model_rx});
        end
      end else begin
        check("rx_data_hold", {20'd0, bus.rx_data}, {20'd0, model_rx});
      end
      if (bus.err) err_cnt++;
      check("oe_vs_busy", {31'd0, bus.miso_oe}, {31'd0, bus.busy});
      if (!bus.busy) check("miso_idle", {31'd0, bus.miso}, 32'd0);
    end else begin
      model_rx = 12'd0;
    end
  end

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    exp_hold = v;
  endtask

  // One frame of nrise sck cycles; completes only when nrise == 12.
  task automatic run_frame(input logic [11:0] word, input int nrise, input bit coincide,
                           input bit mid_load, input bit start_load, input logic [7:0] lval,
                           output logic [11:0] cap_o);
    logic [7:0]  sent;
    logic [11:0] cap;
    logic [11:0] all1;
    logic [11:0] mask;
    logic [11:0] exp_miso;
    int v0;
    int e0;
    bit complete;
    sent = exp_hold;
    complete = (nrise == 12);
    if (complete) exp_q.push_back(word);
    v0 = valid_cnt;
    e0 = err_cnt;
    cap = 12'd0;
    @(negedge clk);
    bus.ss = 1'b0;
    if (start_load) begin
      // tx_load lands on the same clk edge that acts on the ss fall.
      repeat (2) @(negedge clk);
      bus.tx_data = lval;
      bus.tx_load = 1'b1;
      @(negedge clk);
      bus.tx_load = 1'b0;
      exp_hold = lval;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    for (int i = 0; i < nrise; i++) begin
      bus.sck  = 1'b0;
      bus.mosi = word[11-i];
      repeat (HALF) @(negedge clk);
      cap[11-i] = bus.miso;
      bus.sck = 1'b1;
      if (coincide && (i == nrise - 1)) bus.ss = 1'b1;
      repeat (HALF) @(negedge clk);
      if (mid_load && (i == 3)) load(lval);
    end
    if (!coincide) bus.ss = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    all1 = 12'hFFF;
    mask = ~(all1 >> nrise);
    exp_miso = {sent, 4'b0000};
    check("miso_bits", {20'd0, cap & mask}, {20'd0, exp_miso & mask});
    check("rx_valid_count", valid_cnt - v0, complete ? 32'd1 : 32'd0);
    check("err_count", err_cnt - e0, complete ? 32'd0 : 32'd1);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("oe_after", {31'd0, bus.miso_oe}, 32'd0);
    cap_o = cap;
  endtask

  initial begin
    logic [11:0] cap;
    logic [11:0] w;
    int v0;
    int e0;
    total = 0;
    bad = 0;
    valid_cnt = 0;
    err_cnt = 0;
    model_rx = 12'd0;
    exp_hold = 8'd0;
    rst = 1'b1;
    bus.sck = 1'b1;
    bus.ss = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = 8'd0;
    bus.tx_load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", {20'd0, bus.rx_data}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_miso", {31'd0, bus.miso}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Normal frame.
    load(8'hA5);
    run_frame(12'hC3B, 12, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    check("normal_miso_lit", {20'd0, cap}, 32'hA50);
    check("normal_rx_lit", {20'd0, bus.rx_data}, 32'hC3B);

    // Abort after 5 rises, then a normal frame.
    run_frame(12'h5A5, 5, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    check("abort_rx_keep", {20'd0, bus.rx_data}, 32'hC3B);
    run_frame(12'h3E7, 12, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    check("after_abort_rx", {20'd0, bus.rx_data}, 32'h3E7);

    // Reload mid-frame affects only the next frame, then repeats.
    run_frame(12'h123, 12, 1'b0, 1'b1, 1'b0, 8'h3C, cap);
    check("reload_cur", {24'd0, cap[11:4]}, 32'hA5);
    run_frame(12'h456, 12, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    check("reload_next", {24'd0, cap[11:4]}, 32'h3C);
    run_frame(12'h789, 12, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    check("reload_repeat", {24'd0, cap[11:4]}, 32'h3C);

    // tx_load coincident with the ss fall: old value goes out.
    load(8'h11);
    run_frame(12'hABC, 12, 1'b0, 1'b0, 1'b1, 8'h77, cap);
    check("startload_cur", {24'd0, cap[11:4]}, 32'h11);
    run_frame(12'hDEF, 12, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    check("startload_next", {24'd0, cap[11:4]}, 32'h77);

    // Coincident ss rise with the 12th rise completes; with the 11th aborts.
    run_frame(12'h9C4, 12, 1'b1, 1'b0, 1'b0, 8'h00, cap);
    check("coinc12_rx", {20'd0, bus.rx_data}, 32'h9C4);
    run_frame(12'h0F0, 11, 1'b1, 1'b0, 1'b0, 8'h00, cap);
    check("coinc11_rx_keep", {20'd0, bus.rx_data}, 32'h9C4);

    // Reset mid-frame with ss held low.
    w = 12'hB6D;
    @(negedge clk);
    bus.ss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.sck = 1'b0;
      bus.mosi = w[11-i];
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midrst_rx_data", {20'd0, bus.rx_data}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_oe", {31'd0, bus.miso_oe}, 32'd0);
    check("midrst_miso", {31'd0, bus.miso}, 32'd0);
    check("midrst_valid", {31'd0, bus.rx_valid}, 32'd0);
    exp_hold = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.sck = 1'b0;
      bus.mosi = w[5-i];
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    check("wait_busy", {31'd0, bus.busy}, 32'd0);
    check("wait_valid", valid_cnt - v0, 32'd0);
    check("wait_err", err_cnt - e0, 32'd0);
    bus.ss = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    run_frame(12'h5A6, 12, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    check("postrst_hold_zero", {20'd0, cap}, 32'h000);
    load(8'h96);
    run_frame(12'h321, 12, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    check("postrst_miso", {20'd0, cap}, 32'h960);

    // Minimum SCK half period with random words.
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 1) == 1) load(8'($urandom_range(0, 255)));
      run_frame(12'($urandom_range(0, 4095)), 12, 1'b0, 1'b0, 1'b0, 8'h00, cap);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
